sprite_bouncer: RTL and testbench

SPRITE_BOUNCER -- requirements
Module: sprite_bouncer

---
 rtl/sprite_bouncer_pkg.sv | 44 ++++
 rtl/sprite_motion.sv | 116 +++++++++++
 rtl/sprite_bouncer.sv | 139 +++++++++++++
 tb/tb_sprite_bouncer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_bouncer_pkg.sv
// Shared definitions for the bouncing-sprite block: colour depth, default raster geometry,
// palette, motion FSM state encoding and the palette lookup helper.
// No ports (package).
package sprite_bouncer_pkg;

  localparam int unsigned COLOR_BIT_DEPTH  = 4;
  localparam int unsigned POSITION_REG_MAX = 11;
  localparam int unsigned GRAPHICS_WIDTH   = 640;
  localparam int unsigned GRAPHICS_HEIGHT  = 480;

  typedef logic [COLOR_BIT_DEPTH-1:0] color_t;

  typedef struct packed {
    color_t r;
    color_t g;
    color_t b;
  } rgb_t;

  localparam rgb_t BLACK        = '{r: 4'h0, g: 4'h0, b: 4'h0};
  localparam rgb_t BORDER_COLOR = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb_t PALETTE_0    = '{r: 4'hF, g: 4'h0, b: 4'hF};
  localparam rgb_t PALETTE_1    = '{r: 4'h0, g: 4'hF, b: 4'h0};
  localparam rgb_t PALETTE_2    = '{r: 4'hF, g: 4'hF, b: 4'h0};
  localparam rgb_t PALETTE_3    = '{r: 4'h0, g: 4'hF, b: 4'hF};

  typedef enum logic [1:0] {
    StWait = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } motion_state_e;

  function automatic rgb_t palette_color(input logic [1:0] idx);
    rgb_t c;
    c = PALETTE_0;
    case (idx)
      2'd0:    c = PALETTE_0;
      2'd1:    c = PALETTE_1;
      2'd2:    c = PALETTE_2;
      default: c = PALETTE_3;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sprite_motion.sv
// Sprite motion controller: WAIT/RUN/HOLD FSM, per-axis position and direction, wall
// reflection with clamping, bounce pulse and palette index. Everything updates only on
// frame_tick while running.
// Ports:
//   pixel_clock          clock
//   reset_n              synchronous active-low reset
//   frame_tick           one-cycle pulse once per frame
//   freeze               high holds motion (sampled on frame_tick)
//   x_pos, y_pos         sprite top-left corner
//   color_idx            palette index, advances once per reflecting tick
//   bounce               one-cycle pulse after any reflecting tick
module sprite_motion #(
  parameter int unsigned GRAPHICS_WIDTH   = sprite_bouncer_pkg::GRAPHICS_WIDTH,
  parameter int unsigned GRAPHICS_HEIGHT  = sprite_bouncer_pkg::GRAPHICS_HEIGHT,
  parameter int unsigned SPRITE_SIZE      = 32,
  parameter int unsigned SPEED            = 2,
  parameter int unsigned POSITION_REG_MAX = sprite_bouncer_pkg::POSITION_REG_MAX
) (
  input  logic                      pixel_clock,
  input  logic                      reset_n,
  input  logic                      frame_tick,
  input  logic                      freeze,
  output logic [POSITION_REG_MAX:0] x_pos,
  output logic [POSITION_REG_MAX:0] y_pos,
  output logic [1:0]                color_idx,
  output logic                      bounce
);
  import sprite_bouncer_pkg::*;

  localparam int unsigned PosW = POSITION_REG_MAX + 1;
  localparam logic [PosW:0]   StepExt = (PosW + 1)'(SPEED);
  localparam logic [PosW-1:0] XMax    = PosW'(GRAPHICS_WIDTH - SPRITE_SIZE);
  localparam logic [PosW-1:0] YMax    = PosW'(GRAPHICS_HEIGHT - SPRITE_SIZE);

  // Returns {reflected, next position}. The extra bit holds the carry/borrow so that an
  // overshoot is detected instead of wrapping; after clamping the top bit is the flag.
  function automatic logic [PosW:0] axis_step(input logic [PosW-1:0] pos,
                                             input logic            backward,
                                             input logic [PosW-1:0] max_pos);
    logic [PosW:0] pos_ext;
    logic [PosW:0] fwd;
    pos_ext = {1'b0, pos};
    fwd     = pos_ext + StepExt;
    if (backward) begin
      if (pos_ext < StepExt) axis_step = {1'b1, {PosW{1'b0}}};
      else                   axis_step = pos_ext - StepExt;
    end else if (fwd > {1'b0, max_pos}) begin
      axis_step = {1'b1, max_pos};
    end else begin
      axis_step = fwd;
    end
  endfunction

  motion_state_e     state_q, state_d;
  logic [PosW-1:0]   x_q, y_q;
  logic              dir_left_q, dir_up_q;
  logic [1:0]        color_q;
  logic              bounce_q;
  logic              step_en;
  logic [PosW:0]     x_next, y_next;

  always_ff @(posedge pixel_clock) begin : state_reg
    if (!reset_n) state_q <= StWait;
    else          state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      StWait:  if (frame_tick)            state_d = StRun;
      StRun:   if (frame_tick && freeze)  state_d = StHold;
      StHold:  if (frame_tick && !freeze) state_d = StRun;
      default: state_d = StWait;
    endcase
  end

  // A tick that freezes the sprite already counts as held, so it does not step.
  always_comb begin : fsm_outputs
    step_en = (state_q == StRun) && frame_tick && !freeze;
  end

  always_comb begin : axis_update
    x_next = axis_step(x_q, dir_left_q, XMax);
    y_next = axis_step(y_q, dir_up_q, YMax);
  end

  always_ff @(posedge pixel_clock) begin : motion_regs
    if (!reset_n) begin
      x_q        <= '0;
      y_q        <= '0;
      dir_left_q <= 1'b0;
      dir_up_q   <= 1'b0;
      color_q    <= 2'd0;
      bounce_q   <= 1'b0;
    end else begin
      bounce_q <= 1'b0;
      if (step_en) begin
        x_q        <= x_next[PosW-1:0];
        y_q        <= y_next[PosW-1:0];
        dir_left_q <= dir_left_q ^ x_next[PosW];
        dir_up_q   <= dir_up_q ^ y_next[PosW];
        // A corner reflects both axes but is still a single bounce event.
        if (x_next[PosW] || y_next[PosW]) begin
          bounce_q <= 1'b1;
          color_q  <= color_q + 2'd1;
        end
      end
    end
  end

  assign x_pos     = x_q;
  assign y_pos     = y_q;
  assign color_idx = color_q;
  assign bounce    = bounce_q;

endmodule

// File: rtl/sprite_bouncer.sv
// Bouncing square sprite overlay for a VGA raster. A two-stage video pipeline (hit test,
// then colour mux) delays colour and syncs by exactly two pixel clocks; sprite_motion moves
// the sprite once per frame and reflects it off the screen edges.
// Optional build macro SPRITE_BORDER_EN: draws a 1-pixel white outline on the sprite edge.
// Ports:
//   pixel_clock                              pixel clock (sole clock)
//   reset_n                                  synchronous active-low reset
//   h_position, v_position                   current raster column / line
//   visible_area                             high in active video
//   h_sync_in, v_sync_in                     raw active-low syncs
//   freeze                                   high holds sprite motion
//   vga_r, vga_g, vga_b                      pixel colour (2-cycle latency)
//   vga_horizontal_sync, vga_vertical_sync   syncs delayed to match colour
//   bounce                                   one-cycle pulse on any wall reflection
module sprite_bouncer #(
  parameter int unsigned GRAPHICS_WIDTH   = sprite_bouncer_pkg::GRAPHICS_WIDTH,
  parameter int unsigned GRAPHICS_HEIGHT  = sprite_bouncer_pkg::GRAPHICS_HEIGHT,
  parameter int unsigned SPRITE_SIZE      = 32,
  parameter int unsigned SPEED            = 2,
  parameter int unsigned POSITION_REG_MAX = sprite_bouncer_pkg::POSITION_REG_MAX
) (
  input  logic                                           pixel_clock,
  input  logic                                           reset_n,
  input  logic [POSITION_REG_MAX:0]                      h_position,
  input  logic [POSITION_REG_MAX:0]                      v_position,
  input  logic                                           visible_area,
  input  logic                                           h_sync_in,
  input  logic                                           v_sync_in,
  input  logic                                           freeze,
  output logic [sprite_bouncer_pkg::COLOR_BIT_DEPTH-1:0] vga_r,
  output logic [sprite_bouncer_pkg::COLOR_BIT_DEPTH-1:0] vga_g,
  output logic [sprite_bouncer_pkg::COLOR_BIT_DEPTH-1:0] vga_b,
  output logic                                           vga_horizontal_sync,
  output logic                                           vga_vertical_sync,
  output logic                                           bounce
);
  import sprite_bouncer_pkg::*;

  localparam int unsigned PosW = POSITION_REG_MAX + 1;
  localparam int unsigned CmpW = POSITION_REG_MAX + 2;
  localparam logic [PosW-1:0] FrameLine = PosW'(GRAPHICS_HEIGHT);
  localparam logic [CmpW-1:0] SizeExt   = CmpW'(SPRITE_SIZE);

  logic            frame_tick;
  logic [PosW-1:0] x_pos, y_pos;
  logic [1:0]      color_idx;

  // First line after the visible area, column 0: once per frame, outside active video.
  assign frame_tick = (h_position == '0) && (v_position == FrameLine);

  sprite_motion #(
    .GRAPHICS_WIDTH  (GRAPHICS_WIDTH),
    .GRAPHICS_HEIGHT (GRAPHICS_HEIGHT),
    .SPRITE_SIZE     (SPRITE_SIZE),
    .SPEED           (SPEED),
    .POSITION_REG_MAX(POSITION_REG_MAX)
  ) u_motion (
    .pixel_clock(pixel_clock),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .freeze     (freeze),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .color_idx  (color_idx),
    .bounce     (bounce)
  );

  // Hit test one bit wider than the buses so x_pos+SPRITE_SIZE never wraps.
  logic [CmpW-1:0] h_ext, v_ext, x_lo, y_lo, x_hi, y_hi;
  logic            in_sprite;

  always_comb begin : hit_test
    h_ext     = {1'b0, h_position};
    v_ext     = {1'b0, v_position};
    x_lo      = {1'b0, x_pos};
    y_lo      = {1'b0, y_pos};
    x_hi      = x_lo + SizeExt;
    y_hi      = y_lo + SizeExt;
    in_sprite = (h_ext >= x_lo) && (h_ext < x_hi) && (v_ext >= y_lo) && (v_ext < y_hi);
  end

  logic in_sprite_q, visible_q, h_sync_q, v_sync_q;

  always_ff @(posedge pixel_clock) begin : stage1
    if (!reset_n) begin
      in_sprite_q <= 1'b0;
      visible_q   <= 1'b0;
      h_sync_q    <= 1'b1;
      v_sync_q    <= 1'b1;
    end else begin
      in_sprite_q <= in_sprite;
      visible_q   <= visible_area;
      h_sync_q    <= h_sync_in;
      v_sync_q    <= v_sync_in;
    end
  end

`ifdef SPRITE_BORDER_EN
  logic on_edge;
  logic on_edge_q;

  always_comb begin : edge_test
    on_edge = in_sprite && ((h_ext == x_lo) || (h_ext == x_hi - CmpW'(1)) ||
                            (v_ext == y_lo) || (v_ext == y_hi - CmpW'(1)));
  end

  always_ff @(posedge pixel_clock) begin : stage1_edge
    if (!reset_n) on_edge_q <= 1'b0;
    else          on_edge_q <= on_edge;
  end
`endif

  rgb_t pixel_d;

  always_comb begin : colour_mux
    pixel_d = BLACK;
    if (visible_q && in_sprite_q) pixel_d = palette_color(color_idx);
`ifdef SPRITE_BORDER_EN
    if (visible_q && on_edge_q) pixel_d = BORDER_COLOR;
`endif
  end

  always_ff @(posedge pixel_clock) begin : stage2
    if (!reset_n) begin
      vga_r               <= '0;
      vga_g               <= '0;
      vga_b               <= '0;
      vga_horizontal_sync <= 1'b1;
      vga_vertical_sync   <= 1'b1;
    end else begin
      vga_r               <= pixel_d.r;
      vga_g               <= pixel_d.g;
      vga_b               <= pixel_d.b;
      vga_horizontal_sync <= h_sync_q;
      vga_vertical_sync   <= v_sync_q;
    end
  end

endmodule

// File: tb/tb_sprite_bouncer.sv
module tb_sprite_bouncer;

  localparam int Width  = 640;
  localparam int Height = 480;
  localparam int Size   = 32;
  localparam int Speed  = 2;
  localparam int XMax   = Width - Size;
  localparam int YMax   = Height - Size;
`ifdef SPRITE_BORDER_EN
  localparam int EdgeRgb = 'hFFF;
`else
  localparam int EdgeRgb = 'hF0F;
`endif

  logic        pixel_clock = 1'b0;
  logic        reset_n;
  logic [11:0] h_position, v_position;
  logic        visible_area, h_sync_in, v_sync_in, freeze;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_horizontal_sync, vga_vertical_sync, bounce;

  always #20 pixel_clock = ~pixel_clock;

  sprite_bouncer dut (
    .pixel_clock        (pixel_clock),
    .reset_n            (reset_n),
    .h_position         (h_position),
    .v_position         (v_position),
    .visible_area       (visible_area),
    .h_sync_in          (h_sync_in),
    .v_sync_in          (v_sync_in),
    .freeze             (freeze),
    .vga_r              (vga_r),
    .vga_g              (vga_g),
    .vga_b              (vga_b),
    .vga_horizontal_sync(vga_horizontal_sync),
    .vga_vertical_sync  (vga_vertical_sync),
    .bounce             (bounce)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: signed positions, +1/-1 directions, plain integer arithmetic.
  int m_x, m_y, m_dx, m_dy, m_color;
  bit m_started, m_frozen, m_rx, m_ry;
  // Bench copy of what the first video stage holds.
  bit p_in, p_edge, p_vis, p_hs, p_vs;

  function automatic int palette(input int idx);
    case (idx)
      0:       return 'hF0F;
      1:       return 'h0F0;
      2:       return 'hFF0;
      default: return 'h0FF;
    endcase
  endfunction

  function automatic bit in_sprite_at(input int h, input int v);
    return (h >= m_x) && (h < m_x + Size) && (v >= m_y) && (v < m_y + Size);
  endfunction

  function automatic bit on_outline(input int h, input int v);
    return in_sprite_at(h, v) &&
           ((h == m_x) || (h == m_x + Size - 1) || (v == m_y) || (v == m_y + Size - 1));
  endfunction

  function automatic void model_reset();
    m_x = 0; m_y = 0; m_dx = 1; m_dy = 1; m_color = 0;
    m_started = 0; m_frozen = 0;
    p_in = 0; p_edge = 0; p_vis = 0; p_hs = 1; p_vs = 1;
  endfunction

  function automatic void model_tick(input bit frz);
    int nx, ny;
    if (!m_started) m_started = 1;
    else if (m_frozen) begin
      if (!frz) m_frozen = 0;
    end else if (frz) m_frozen = 1;
    else begin
      nx = m_x + m_dx * Speed;
      ny = m_y + m_dy * Speed;
      if (nx < 0)         begin nx = 0;    m_dx = -m_dx; m_rx = 1; end
      else if (nx > XMax) begin nx = XMax; m_dx = -m_dx; m_rx = 1; end
      if (ny < 0)         begin ny = 0;    m_dy = -m_dy; m_ry = 1; end
      else if (ny > YMax) begin ny = YMax; m_dy = -m_dy; m_ry = 1; end
      m_x = nx; m_y = ny;
      if (m_rx || m_ry) m_color = (m_color + 1) % 4;
    end
  endfunction

  // One pixel clock: apply inputs, advance the model, compare every output after the edge.
  task automatic drive_cycle(input int h, input int v, input bit vis, input bit hs,
                             input bit vs, input bit frz);
    int exp_rgb;
    bit exp_hs, exp_vs, n_in, n_edge, tick;
    exp_rgb = 0;
    if (p_vis && p_in) exp_rgb = palette(m_color);
`ifdef SPRITE_BORDER_EN
    if (p_vis && p_edge) exp_rgb = 'hFFF;
`endif
    exp_hs = p_hs;
    exp_vs = p_vs;
    n_in   = in_sprite_at(h, v);
    n_edge = on_outline(h, v);
    h_position   = 12'(h);
    v_position   = 12'(v);
    visible_area = vis;
    h_sync_in    = hs;
    v_sync_in    = vs;
    freeze       = frz;
    tick = (h == 0) && (v == Height);
    m_rx = 0;
    m_ry = 0;
    if (tick) model_tick(frz);
    @(posedge pixel_clock);
    #1;
    p_in = n_in; p_edge = n_edge; p_vis = vis; p_hs = hs; p_vs = vs;
    check("rgb", 32'({vga_r, vga_g, vga_b}), exp_rgb);
    check("hsync", 32'(vga_horizontal_sync), 32'(exp_hs));
    check("vsync", 32'(vga_vertical_sync), 32'(exp_vs));
    check("bounce", 32'(bounce), 32'(m_rx | m_ry));
    if (tick) begin
      check("x_pos", 32'(dut.u_motion.x_pos), m_x);
      check("y_pos", 32'(dut.u_motion.y_pos), m_y);
      check("color_idx", 32'(dut.u_motion.color_idx), m_color);
    end
  endtask

  // A frame is a tick cycle followed by one visible pixel inside the sprite.
  task automatic frame(input bit frz, output bit rx, output bit ry);
    drive_cycle(0, Height, 0, 1, 1, frz);
    rx = m_rx;
    ry = m_ry;
    drive_cycle(m_x + 5, m_y + 5, 1, 1, 1, frz);
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    h_position   = 12'd0;
    v_position   = 12'(Height);
    visible_area = 1'b1;
    h_sync_in    = 1'b0;
    v_sync_in    = 1'b0;
    freeze       = 1'b0;
    repeat (2) @(posedge pixel_clock);
    #1;
    check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
    check("rst_hsync", 32'(vga_horizontal_sync), 1);
    check("rst_vsync", 32'(vga_vertical_sync), 1);
    check("rst_bounce", 32'(bounce), 0);
    check("rst_x", 32'(dut.u_motion.x_pos), 0);
    check("rst_y", 32'(dut.u_motion.y_pos), 0);
    check("rst_color", 32'(dut.u_motion.color_idx), 0);
    reset_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int h;
    int v;
    bit vis;
    bit hs;
    bit vs;
    int rgb;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit rx, ry, found_wall, found_corner;
    int prev_color, fx, fy;

    vecs[0] = '{h: 0,    v: 0,    vis: 1, hs: 0, vs: 1, rgb: EdgeRgb};
    vecs[1] = '{h: 5,    v: 5,    vis: 1, hs: 1, vs: 0, rgb: 'hF0F};
    vecs[2] = '{h: 31,   v: 5,    vis: 1, hs: 0, vs: 0, rgb: EdgeRgb};
    vecs[3] = '{h: 32,   v: 5,    vis: 1, hs: 1, vs: 1, rgb: 0};
    vecs[4] = '{h: 5,    v: 31,   vis: 1, hs: 0, vs: 1, rgb: EdgeRgb};
    vecs[5] = '{h: 5,    v: 32,   vis: 1, hs: 1, vs: 0, rgb: 0};
    vecs[6] = '{h: 10,   v: 10,   vis: 0, hs: 0, vs: 0, rgb: 0};
    vecs[7] = '{h: 31,   v: 31,   vis: 1, hs: 1, vs: 1, rgb: EdgeRgb};
    vecs[8] = '{h: 4095, v: 4095, vis: 1, hs: 0, vs: 1, rgb: 0};
    vecs[9] = '{h: 20,   v: 3,    vis: 1, hs: 1, vs: 1, rgb: 'hF0F};

    do_reset();

    // Table: output after edge i must reflect the vector applied before edge i-1.
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        h_position   = 12'(vecs[i].h);
        v_position   = 12'(vecs[i].v);
        visible_area = vecs[i].vis;
        h_sync_in    = vecs[i].hs;
        v_sync_in    = vecs[i].vs;
      end else begin
        h_position   = 12'd100;
        v_position   = 12'd100;
        visible_area = 1'b0;
        h_sync_in    = 1'b1;
        v_sync_in    = 1'b1;
      end
      @(posedge pixel_clock);
      #1;
      if (i == 0) begin
        check("pipe_clear_rgb", 32'({vga_r, vga_g, vga_b}), 0);
        check("pipe_clear_hs", 32'(vga_horizontal_sync), 1);
      end else begin
        check("vec_rgb", 32'({vga_r, vga_g, vga_b}), vecs[i-1].rgb);
        check("vec_hsync", 32'(vga_horizontal_sync), 32'(vecs[i-1].hs));
        check("vec_vsync", 32'(vga_vertical_sync), 32'(vecs[i-1].vs));
      end
    end

    // Three ticks from reset: the first only leaves WAIT, then two steps of 2.
    do_reset();
    repeat (3) frame(0, rx, ry);
    check("three_ticks_x", 32'(dut.u_motion.x_pos), 4);
    check("three_ticks_y", 32'(dut.u_motion.y_pos), 4);

    // Reset mid-frame, then the first tick must not move the sprite.
    drive_cycle(100, 200, 1, 0, 1, 0);
    do_reset();
    drive_cycle(3, 3, 1, 1, 1, 0);
    frame(0, rx, ry);
    check("post_reset_hold_x", 32'(dut.u_motion.x_pos), 0);
    frame(0, rx, ry);
    check("post_reset_step_x", 32'(dut.u_motion.x_pos), Speed);

    // Run until a tick reflects both axes at once.
    found_wall   = 0;
    found_corner = 0;
    for (int i = 0; i < 20000 && !found_corner; i++) begin
      prev_color = m_color;
      frame(0, rx, ry);
      if (rx && !found_wall && m_x == XMax) begin
        found_wall = 1;
        check("wall_x", 32'(dut.u_motion.x_pos), XMax);
        check("wall_color", 32'(dut.u_motion.color_idx), (prev_color + 1) % 4);
        frame(0, rx, ry);
        check("wall_turned_left", 32'(dut.u_motion.x_pos), XMax - Speed);
      end else if (rx && ry) begin
        found_corner = 1;
        check("corner_color_once", 32'(dut.u_motion.color_idx), (prev_color + 1) % 4);
      end
    end
    check("wall_reached", 32'(found_wall), 1);
    check("corner_reached", 32'(found_corner), 1);

    // Freeze across five ticks, then release.
    fx = m_x;
    fy = m_y;
    for (int i = 0; i < 5; i++) begin
      frame(1, rx, ry);
      check("frozen_x", 32'(dut.u_motion.x_pos), fx);
      check("frozen_y", 32'(dut.u_motion.y_pos), fy);
    end
    frame(0, rx, ry);
    check("release_tick_x", 32'(dut.u_motion.x_pos), fx);
    frame(0, rx, ry);
    check("resume_x", 32'(dut.u_motion.x_pos), fx + m_dx * Speed);

    // Outline column, interior and the pixel just left of the sprite.
    drive_cycle(m_x, m_y + 5, 1, 1, 1, 0);
    drive_cycle(m_x + 5, m_y + 5, 1, 1, 1, 0);
    drive_cycle(m_x - 1, m_y + 5, 1, 1, 1, 0);
    drive_cycle(m_x + Size - 1, m_y + Size - 1, 1, 0, 0, 0);
    drive_cycle(m_x + Size, m_y + 5, 1, 1, 1, 0);
    drive_cycle(10, 10, 0, 1, 1, 0);

    // Random pixels near the sprite, random ticks and freeze.
    for (int i = 0; i < 3000; i++) begin
      int r, h, v;
      bit frz;
      r   = int'($urandom_range(0, 7));
      frz = ($urandom_range(0, 2) == 0);
      if (r == 0) begin
        drive_cycle(0, Height, 0, 1, 1, frz);
      end else begin
        h = m_x + int'($urandom_range(0, 40)) - 4;
        v = m_y + int'($urandom_range(0, 40)) - 4;
        if (h < 0) h = 0;
        if (v < 0) v = 0;
        drive_cycle(h, v, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), frz);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
